// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter that shares one multi-cycle fpu among NREQ requesters,
// holding operands for LAT cycles and returning each result with a one-cycle pulse.
module fpu_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [2*NREQ-1:0]    req_op,
  output logic [31:0]          fpu_a,
  output logic [31:0]          fpu_b,
  output logic [1:0]           fpu_opcode,
  input  logic [31:0]          fpu_o,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 busy
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, nxt;
  logic [PW-1:0] ptr, owner, g;
  logic [CW-1:0] cnt;
  logic found;
  logic [PW+4:0] sel_w;
  logic [PW:0] sel_op;
  // first valid requester at or above ptr, wrapping
  always_comb begin
    found = 1'b0;
    g = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[PW'((int'(ptr) + k) % NREQ)]) begin
        found = 1'b1;
        g = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end
  assign sel_w = {g, 5'd0};
  assign sel_op = {g, 1'b0};
  assign busy = state != IDLE;
  always_comb begin
    nxt = (state == IDLE) ? (found ? BUSY : IDLE) :
          (state == BUSY) ? ((cnt == '0) ? RESP : BUSY) : IDLE;
    req_ready = (state == IDLE && found && !rst) ? NREQ'(1) << g : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      fpu_a      <= '0;
      fpu_b      <= '0;
      fpu_opcode <= '0;
      rsp_data   <= '0;
      rsp_valid  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && found) begin
        fpu_a      <= req_a[sel_w +: 32];
        fpu_b      <= req_b[sel_w +: 32];
        fpu_opcode <= req_op[sel_op +: 2];
        owner      <= g;
        ptr        <= PW'((int'(g) + 1) % NREQ);
        cnt        <= CW'(LAT - 1);
      end
      if (state == BUSY) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          rsp_data  <= fpu_o;
          rsp_valid <= NREQ'(1) << owner;
        end
      end
      if (state == RESP) rsp_valid <= '0;
    end
  end
endmodule
